// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants for the register-level I2C/SCCB sequencer
// Purpose: engine command one-hot bits, sequencer FSM states, step indices.
package i2c_pkg;

  // Engine command bits (one-hot, OR-ed together per step)
  localparam logic [5:0] WR   = 6'b000001;
  localparam logic [5:0] STA  = 6'b000010;
  localparam logic [5:0] RD   = 6'b000100;
  localparam logic [5:0] STO  = 6'b001000;
  localparam logic [5:0] ACK  = 6'b010000;
  localparam logic [5:0] NACK = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Step indices; S_ABORT is the bus-release step used after a NACK
  localparam logic [2:0] S0      = 3'd0;
  localparam logic [2:0] S1      = 3'd1;
  localparam logic [2:0] S2      = 3'd2;
  localparam logic [2:0] S3      = 3'd3;
  localparam logic [2:0] S4      = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

endpackage

// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - register write/read sequencer driving a byte-level I2C engine
// Purpose: splits one register write or read request into engine transactions
//   (Cmd/Go/Trans_Done handshake) and returns read data, done pulse and ack error.
// Ports:
//   Clk, Rst                 clock, asynchronous active-high reset
//   wrreg_req, rdreg_req     request strobes (sampled in IDLE, write wins)
//   Dev_Addr, Reg_Addr,
//   Addr_Mode, Wr_Data       request fields, latched on acceptance
//   Rd_Data, RW_Done,
//   Ack_Err, Busy            results to the init sequencer
//   Cmd, Go, Tx_DATA         engine command interface
//   Rx_DATA, Trans_Done,
//   ack_o                    engine response interface
// Configuration: define I2C_ACK_CHECK_EN to abort on slave NACK.
module i2c_reg_ctrl
  import i2c_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wrreg_req,
  input  logic        rdreg_req,
  input  logic [6:0]  Dev_Addr,
  input  logic [15:0] Reg_Addr,
  input  logic        Addr_Mode,
  input  logic [7:0]  Wr_Data,
  output logic [7:0]  Rd_Data,
  output logic        RW_Done,
  output logic        Ack_Err,
  output logic        Busy,
  output logic [5:0]  Cmd,
  output logic        Go,
  output logic [7:0]  Tx_DATA,
  input  logic [7:0]  Rx_DATA,
  input  logic        Trans_Done,
  input  logic        ack_o
);

  state_t      state, next_state;
  logic [2:0]  step, step_next;
  logic        is_rd;
  logic [6:0]  dev;
  logic [15:0] reg_addr;
  logic        mode16;
  logic [7:0]  wr_data;
  logic [5:0]  step_cmd;
  logic [7:0]  step_tx;
  logic        nack_hit;
  logic        last_step;

`ifdef I2C_ACK_CHECK_EN
  logic ack_err_q;
`else
  logic unused_ack;
  assign unused_ack = ack_o;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      step     <= S0;
      is_rd    <= 1'b0;
      dev      <= '0;
      reg_addr <= '0;
      mode16   <= 1'b0;
      wr_data  <= '0;
      Rd_Data  <= '0;
`ifdef I2C_ACK_CHECK_EN
      ack_err_q <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (wrreg_req || rdreg_req) begin
            is_rd    <= ~wrreg_req;
            dev      <= Dev_Addr;
            reg_addr <= Reg_Addr;
            mode16   <= Addr_Mode;
            wr_data  <= Wr_Data;
            step     <= S0;
`ifdef I2C_ACK_CHECK_EN
            ack_err_q <= 1'b0;
`endif
          end
        end
        // Capture on the completion edge so Rd_Data is already valid in NEXT,
        // one cycle ahead of RW_Done.
        ST_WAIT: if (Trans_Done && step == S4) Rd_Data <= Rx_DATA;
        ST_NEXT: begin
          step <= step_next;
`ifdef I2C_ACK_CHECK_EN
          if (nack_hit) ack_err_q <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Step-to-command decode
  always_comb begin
    step_cmd = '0;
    step_tx  = '0;
    case (step)
      S0: begin step_cmd = STA | WR; step_tx = {dev, 1'b0}; end
      S1: begin step_cmd = WR; step_tx = reg_addr[15:8]; end
      S2: begin step_cmd = is_rd ? (WR | STO) : WR; step_tx = reg_addr[7:0]; end
      S3: begin
        step_cmd = is_rd ? (STA | WR) : (WR | STO);
        step_tx  = is_rd ? {dev, 1'b1} : wr_data;
      end
      S4:      begin step_cmd = RD | NACK | STO; step_tx = 8'h00; end
      S_ABORT: begin step_cmd = WR | STO; step_tx = 8'hFF; end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    step_next  = step;
    nack_hit   = 1'b0;
    last_step  = (step == S_ABORT) || (!is_rd && step == S3) || (is_rd && step == S4);
`ifdef I2C_ACK_CHECK_EN
    nack_hit   = ack_o && ((step_cmd & WR) != 6'd0);
`endif
    case (state)
      ST_IDLE:   if (wrreg_req || rdreg_req) next_state = ST_ISSUE;
      ST_ISSUE:  next_state = ST_WAIT;
      ST_WAIT:   if (Trans_Done) next_state = ST_NEXT;
      ST_NEXT: begin
        if (nack_hit && ((step_cmd & STO) == 6'd0)) begin
          // bus still held by the slave transaction: release it with a stop
          step_next  = S_ABORT;
          next_state = ST_ISSUE;
        end else if (nack_hit || last_step) begin
          next_state = ST_FINISH;
        end else begin
          next_state = ST_ISSUE;
          case (step)
            S0:      step_next = mode16 ? S1 : S2;
            S1:      step_next = S2;
            S2:      step_next = S3;
            S3:      step_next = S4;
            default: step_next = step;
          endcase
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign Go      = (state == ST_ISSUE);
  assign Cmd     = (state == ST_ISSUE || state == ST_WAIT) ? step_cmd : 6'd0;
  assign Tx_DATA = (state == ST_ISSUE || state == ST_WAIT) ? step_tx : 8'd0;
  assign RW_Done = (state == ST_FINISH);
  assign Busy    = (state != ST_IDLE);
`ifdef I2C_ACK_CHECK_EN
  assign Ack_Err = (state == ST_FINISH) && ack_err_q;
`else
  assign Ack_Err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb/tb_i2c_reg_ctrl.sv - self-checking bench for i2c_reg_ctrl with an engine model
module tb_i2c_reg_ctrl;

  localparam logic [5:0] C_WR = 6'b000001, C_STA = 6'b000010, C_RD = 6'b000100;
  localparam logic [5:0] C_STO = 6'b001000, C_NACK = 6'b100000;

  logic        Clk = 1'b0, Rst = 1'b1;
  logic        wrreg_req = 1'b0, rdreg_req = 1'b0;
  logic [6:0]  Dev_Addr = '0;
  logic [15:0] Reg_Addr = '0;
  logic        Addr_Mode = 1'b0;
  logic [7:0]  Wr_Data = '0;
  logic [7:0]  Rd_Data;
  logic        RW_Done, Ack_Err, Busy, Go;
  logic [5:0]  Cmd;
  logic [7:0]  Tx_DATA;
  logic [7:0]  Rx_DATA = '0;
  logic        Trans_Done = 1'b0;
  logic        ack_o = 1'b0;

  i2c_reg_ctrl dut (
    .Clk(Clk), .Rst(Rst), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
    .Dev_Addr(Dev_Addr), .Reg_Addr(Reg_Addr), .Addr_Mode(Addr_Mode), .Wr_Data(Wr_Data),
    .Rd_Data(Rd_Data), .RW_Done(RW_Done), .Ack_Err(Ack_Err), .Busy(Busy),
    .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA),
    .Trans_Done(Trans_Done), .ack_o(ack_o)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int passed = 0, total = 0;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  int go_cnt = 0, done_cnt = 0;
  int go_wide_err = 0, gap_err = 0, stable_err = 0, done_gap_err = 0;
  int last_td_cyc = 0, first_go_cyc = -1;
  bit td_armed = 0;
  logic [7:0] done_rd = '0, rd_before_done = '0, prev_rd = '0;
  logic done_err = 1'b0, prev_go = 1'b0;
  int txn_idx = 0, nack_at = -1;
  logic [7:0] rx_val = '0;
  logic [7:0] exp_rd = '0;

  // Output monitor: records Go commands and done results, checks pulse timing
  always @(negedge Clk) begin
    if (Go === 1'b1) begin
      obs_q.push_back({Cmd, Tx_DATA});
      if (first_go_cyc < 0) first_go_cyc = cyc;
      if (prev_go === 1'b1) go_wide_err++;
      if (td_armed && (cyc - last_td_cyc != 2)) gap_err++;
      td_armed = 0;
      go_cnt++;
    end
    if (RW_Done === 1'b1) begin
      done_rd        = Rd_Data;
      rd_before_done = prev_rd;
      done_err       = Ack_Err;
      if (cyc - last_td_cyc != 2) done_gap_err++;
      td_armed = 0;
      done_cnt++;
    end
    prev_go = Go;
    prev_rd = Rd_Data;
  end

  // Engine model: 3 cycles of WAIT, then a one-cycle Trans_Done
  logic [13:0] held;
  bit eng_abort;
  always begin
    @(negedge Clk);
    if (Go === 1'b1 && !Rst) begin
      held = {Cmd, Tx_DATA};
      ack_o = 1'b0;
      eng_abort = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge Clk);
        if (Rst) begin eng_abort = 1; break; end
        if ({Cmd, Tx_DATA} !== held) stable_err++;
      end
      if (!eng_abort) begin
        Trans_Done  = 1'b1;
        ack_o       = (txn_idx == nack_at);
        Rx_DATA     = rx_val;
        last_td_cyc = cyc;
        td_armed    = 1;
        txn_idx++;
        @(negedge Clk);
        Trans_Done = 1'b0;
      end
    end
  end

  task automatic run_req(input bit wr, input bit rd, input logic [6:0] dev, input bit mode,
                         input logic [15:0] ra, input logic [7:0] wd, input logic [7:0] rx,
                         input int nack, input bit poke, input string name);
    logic [13:0] full[$];
    bit is_rd, err;
    int req_cyc, start, n, gstart;
    is_rd = rd && !wr;
    err = 0;
    full.delete();
    full.push_back({C_STA | C_WR, dev, 1'b0});
    if (mode) full.push_back({C_WR, ra[15:8]});
    if (!is_rd) begin
      full.push_back({C_WR, ra[7:0]});
      full.push_back({C_WR | C_STO, wd});
    end else begin
      full.push_back({C_WR | C_STO, ra[7:0]});
      full.push_back({C_STA | C_WR, dev, 1'b1});
      full.push_back({C_RD | C_NACK | C_STO, 8'h00});
    end
    exp_q.delete();
    obs_q.delete();
    foreach (full[i]) begin
      exp_q.push_back(full[i]);
`ifdef I2C_ACK_CHECK_EN
      if (i == nack && full[i][8]) begin
        err = 1;
        if (!full[i][11]) exp_q.push_back({C_WR | C_STO, 8'hFF});
        break;
      end
`endif
    end
    if (is_rd && !err) exp_rd = rx;

    txn_idx = 0; nack_at = nack; rx_val = rx; first_go_cyc = -1; td_armed = 0;
    go_wide_err = 0; gap_err = 0; stable_err = 0; done_gap_err = 0;
    gstart = go_cnt;
    Dev_Addr = dev; Reg_Addr = ra; Addr_Mode = mode; Wr_Data = wd;
    start = done_cnt;
    @(negedge Clk);
    wrreg_req = wr; rdreg_req = rd; req_cyc = cyc;
    @(negedge Clk);
    wrreg_req = 0; rdreg_req = 0;
    // scramble latched inputs to prove they are held internally
    Dev_Addr = ~dev; Reg_Addr = ~ra; Wr_Data = ~wd;
    if (poke) begin
      repeat (4) @(negedge Clk);
      rdreg_req = 1;
      @(negedge Clk);
      rdreg_req = 0;
    end
    n = 0;
    while (done_cnt == start && n < 300) begin @(negedge Clk); n++; end
    repeat (8) @(negedge Clk);

    total++;
    if (done_cnt != start + 1) $display("FAIL %s done_count got=%0d want=%0d", name, done_cnt - start, 1);
    else passed++;
    total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL %s go_count got=%0d want=%0d", name, obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [13:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) $display("FAIL %s cmd/tx got=%h/%h want=%h/%h", name, o[13:8], o[7:0], e[13:8], e[7:0]);
      else passed++;
    end
    total++;
    if (done_err !== err) $display("FAIL %s ack_err got=%b want=%b", name, done_err, err);
    else passed++;
    total++;
    if (done_rd !== exp_rd) $display("FAIL %s rd_data got=%h want=%h", name, done_rd, exp_rd);
    else passed++;
    if (is_rd && !err) begin
      total++;
      if (rd_before_done !== exp_rd) $display("FAIL %s rd_data_early got=%h want=%h", name, rd_before_done, exp_rd);
      else passed++;
    end
    total++;
    if (first_go_cyc - req_cyc != 1) $display("FAIL %s go_latency got=%0d want=1", name, first_go_cyc - req_cyc);
    else passed++;
    total++;
    if (go_wide_err + gap_err != 0) $display("FAIL %s go_timing got=%0d want=0", name, go_wide_err + gap_err);
    else passed++;
    total++;
    if (stable_err != 0) $display("FAIL %s cmd_stable got=%0d want=0", name, stable_err);
    else passed++;
    total++;
    if (done_gap_err != 0) $display("FAIL %s done_latency got=%0d want=0", name, done_gap_err);
    else passed++;
    total++;
    if (Busy !== 1'b0) $display("FAIL %s busy_after got=%b want=0", name, Busy);
    else passed++;
    if (go_cnt - gstart > 16) $display("FAIL %s runaway got=%0d want<=16", name, go_cnt - gstart);
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if ({Cmd, Go, Tx_DATA, Rd_Data, RW_Done, Ack_Err, Busy} !== 27'd0)
      $display("FAIL %s outputs got=%h/%b/%h/%h/%b/%b/%b want=all zero", name,
               Cmd, Go, Tx_DATA, Rd_Data, RW_Done, Ack_Err, Busy);
    else passed++;
  endtask

  task automatic test_reset();
    int g;
    repeat (3) @(negedge Clk);
    check_zero_outputs("reset");
    Rst = 1'b0;
    @(negedge Clk);
    g = go_cnt;
    Trans_Done = 1'b1;
    @(negedge Clk);
    Trans_Done = 1'b0;
    repeat (4) @(negedge Clk);
    total++;
    if (go_cnt != g || Busy !== 1'b0) $display("FAIL idle_trans_done go=%0d busy=%b want=0/0", go_cnt - g, Busy);
    else passed++;
  endtask

  task automatic test_write();
    run_req(1, 0, 7'h3C, 1, 16'h3008, 8'h82, 8'h00, -1, 0, "write16");
    run_req(1, 0, 7'h10, 0, 16'hAB55, 8'hC3, 8'h00, -1, 0, "write8");
  endtask

  task automatic test_read();
    run_req(0, 1, 7'h21, 0, 16'h000A, 8'h00, 8'h76, -1, 0, "read8");
    run_req(0, 1, 7'h5A, 1, 16'h1234, 8'h00, 8'hE1, -1, 0, "read16");
  endtask

  task automatic test_back_to_back();
    run_req(1, 1, 7'h3C, 0, 16'h0011, 8'h99, 8'h5A, -1, 1, "simul_busy");
  endtask

  task automatic test_nack();
    run_req(1, 0, 7'h3C, 1, 16'h3008, 8'h82, 8'h00, 0, 0, "nack_s0");
    run_req(0, 1, 7'h21, 0, 16'h000A, 8'h00, 8'h33, 1, 0, "nack_sto");
  endtask

  task automatic test_reset_mid();
    int target, n;
    txn_idx = 0; nack_at = -1;
    target = go_cnt + 3;
    Dev_Addr = 7'h3C; Reg_Addr = 16'h3008; Addr_Mode = 1; Wr_Data = 8'h82;
    @(negedge Clk);
    wrreg_req = 1;
    @(negedge Clk);
    wrreg_req = 0;
    n = 0;
    while (go_cnt < target && n < 100) begin @(negedge Clk); n++; end
    @(negedge Clk);
    total++;
    if (Busy !== 1'b1 || Go !== 1'b0) $display("FAIL mid_wait busy=%b go=%b want=1/0", Busy, Go);
    else passed++;
    Rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid");
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    exp_rd = 8'h00;
    run_req(1, 0, 7'h3C, 1, 16'h3008, 8'h82, 8'h00, -1, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_nack();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
